seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits; legal values are WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 The block SHALL have port dividend, input, WIDTH bits: unsigned numerator; sampled with start.
REQ-006 The block SHALL have port divisor, input, WIDTH bits: unsigned denominator; sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking results valid.
REQ-009 The block SHALL have port quotient, output, WIDTH bits: registered result.
REQ-010 The block SHALL have port remainder, output, WIDTH bits: registered result.
REQ-011 The block SHALL have port div_by_zero, output, 1 bit: registered flag for the last completed operation.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE; busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.
REQ-013 In IDLE with start=1 and divisor!=0 at edge 0, the block SHALL capture the operands, clear the partial remainder, load an iteration counter with WIDTH, and enter RUN.
REQ-014 In IDLE with start=1 and divisor==0, the block SHALL enter DONE at the next edge with quotient = all ones, remainder = dividend and div_by_zero=1; the latency is 1 edge.
REQ-015 Each RUN edge SHALL perform one restoring step: shift the partial remainder left 1, shift in the dividend MSB, do a (WIDTH+1)-bit trial subtract of the divisor, keep the difference and shift in quotient bit 1 if it is non-negative, otherwise keep the shifted value and shift in 0.
REQ-016 After exactly WIDTH RUN edges (edges 1..WIDTH), the block SHALL register quotient and remainder, clear div_by_zero, and enter DONE; done SHALL be high between edge WIDTH and edge WIDTH+1.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-018 quotient, remainder and div_by_zero SHALL change only on entry to DONE and SHALL hold their values until the next completion.
REQ-019 start SHALL be ignored in RUN and DONE, including start held high; a new operation SHALL be accepted no earlier than the first IDLE cycle.
REQ-020 Changes to dividend or divisor after acceptance SHALL NOT affect the operation in progress.
REQ-021 Results SHALL satisfy dividend == quotient*divisor + remainder and remainder < divisor for every divisor != 0, including dividend=0, dividend<divisor and dividend=all ones.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, with busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, and all internal registers cleared, regardless of clk.
REQ-023 Reset asserted mid-RUN SHALL abort the operation without producing a done pulse; the first start after rst_n deasserts SHALL be processed normally.

Verification (WIDTH=8)
REQ-024 Start 100/7 -> busy high for 8 cycles, then a single done pulse with quotient=14, remainder=2, div_by_zero=0.
REQ-025 Start 255/1 -> quotient=255, remainder=0; start 5/9 -> quotient=0, remainder=5; start 0/3 -> quotient=0, remainder=0.
REQ-026 Start 37/0 -> done after 1 edge with busy never high, quotient=255, remainder=37, div_by_zero=1; a following 9/3 -> quotient=3, remainder=0, div_by_zero=0.
REQ-027 Start 100/7 with start held high and the operands changed to 50/5 during RUN -> result 14 rem 2 with exactly one done pulse; the second operation starts only in the IDLE cycle after DONE.
REQ-028 Pull rst_n low at RUN cycle 4 of 100/7 -> all outputs 0 asynchronously and no done pulse; after release, start 200/13 -> quotient=15, remainder=5.
REQ-029 The bench SHALL run at least 1000 random operand pairs, including divisor=0, and check REQ-021 and the 8-edge latency against a reference model.

Source files
------------

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock, with divide-by-zero shortcut
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] acc, dvs, part, low, part_nx;
    logic [CW-1:0]    cnt;
    logic             qbit, last;
    // trial subtract: the shifted-out partial remainder MSB acts as the extra (WIDTH+1)th bit
    always_comb begin
        low     = {part[WIDTH-2:0], acc[WIDTH-1]};
        qbit    = part[WIDTH-1] | (low >= dvs);
        part_nx = qbit ? low - dvs : low;
        last    = cnt == CW'(1);
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    // next state and status outputs
    always_comb begin
        busy     = state == RUN;
        done     = state == DONE;
        state_nx = state == IDLE ? (start ? (divisor == '0 ? DONE : RUN) : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) : IDLE;
    end
    // datapath: acc shifts dividend bits out and quotient bits in; results load only on entry to DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            dvs         <= '0;
            part        <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (state == IDLE && start) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                acc  <= dividend;
                dvs  <= divisor;
                part <= '0;
                cnt  <= CW'(WIDTH);
            end
        end else if (state == RUN) begin
            acc  <= {acc[WIDTH-2:0], qbit};
            part <= part_nx;
            cnt  <= cnt - CW'(1);
            if (last) begin
                quotient    <= {acc[WIDTH-2:0], qbit};
                remainder   <= part_nx;
                div_by_zero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: scoreboard bench for seq_divider with directed cases, reset abort and random operands
module tb_seq_divider;
    localparam int W = 8;
    typedef struct {
        logic [W-1:0] a, b, q, r;
        logic         z;
        int           issue, lat, bsy;
    } exp_t;
    logic         clk = 1'b0, rst_n = 1'b1, start = 1'b0;
    logic [W-1:0] dividend = '0, divisor = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] quotient, remainder;
    exp_t         sb[$];
    exp_t         e;
    int           n_cmp = 0, n_err = 0, cyc = 0, busy_run = 0, issued = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input int issue);
        exp_t x;
        x.a     = a;
        x.b     = b;
        x.z     = b == 0;
        x.q     = x.z ? {W{1'b1}} : a / b;
        x.r     = x.z ? a : a % b;
        x.issue = issue;
        x.lat   = x.z ? 1 : W + 1;
        x.bsy   = x.z ? 0 : W;
        return x;
    endfunction

    // compares each done pulse against the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) chk("spurious_done", 1, 0);
            else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.z);
                chk("latency", cyc - e.issue, e.lat);
                chk("busy_cycles", busy_run, e.bsy);
                if (!e.z) begin
                    chk("identity", 32'(quotient) * 32'(e.b) + 32'(remainder), e.a);
                    chk("rem_lt_div", remainder < e.b, 1);
                end
            end
        end
        busy_run = busy ? busy_run + 1 : 0;
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && (busy || done); i++) @(negedge clk);
        if (busy || done) chk("idle_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        wait_idle();
    endtask

    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b);
        wait_idle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        issued   = cyc;
        sb.push_back(mk(a, b, cyc));
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op(8'd100, 8'd7);
        op(8'd255, 8'd1);
        op(8'd5, 8'd9);
        op(8'd0, 8'd3);
        op(8'd37, 8'd0);
        op(8'd9, 8'd3);
        op(8'd255, 8'd255);
        op(8'd254, 8'd255);
        drain();
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        issued   = cyc;
        sb.push_back(mk(8'd100, 8'd7, issued));
        sb.push_back(mk(8'd50, 8'd5, issued + W + 2));
        @(negedge clk);
        dividend = 8'd50;
        divisor  = 8'd5;
        repeat (W + 2) @(negedge clk);
        start = 1'b0;
        drain();
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_run_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", div_by_zero, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) @(negedge clk);
        op(8'd200, 8'd13);
        drain();
        for (int i = 0; i < 1000; i++)
            op(W'($urandom), ($urandom_range(0, 7) == 0) ? '0 : W'($urandom));
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
